// File: rtl/pipeline_types_pkg.sv
// Shared pipeline stage payload types and sizing helpers for the inter-stage
// elastic registers.
package pipeline_types;

    localparam int PipeStageDepth = 2;

    typedef logic [15:0] stall_cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam int IfIdW  = $bits(if_id_t);
    localparam int IdExW  = $bits(id_ex_t);
    localparam int ExMemW = $bits(ex_mem_t);
    localparam int MemWbW = $bits(mem_wb_t);

    // A single-entry buffer still needs a 1-bit pointer to keep port widths legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_elastic_stage_mem.sv
// DEPTH x PAYLOAD_W register array: one write port, one async read port,
// contents cleared only by reset.
module pipe_stage_mem
    import pipeline_types::*;
#(
    parameter int DEPTH     = PipeStageDepth,
    parameter int PAYLOAD_W = IfIdW,
    parameter int AW        = ptr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [PAYLOAD_W-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [PAYLOAD_W-1:0] rdata
);

    logic [DEPTH-1:0][PAYLOAD_W-1:0] mem;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                mem[i] <= '0;
            end else if (we && waddr == AW'(i)) begin
                mem[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) rdata = mem[i];
        end
    end

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic inter-stage register: valid/ready skid buffer with flush and a
// saturating downstream-stall counter. up_ready comes from registered state only.
module pipe_elastic_stage
    import pipeline_types::*;
#(
    parameter int PAYLOAD_W   = IfIdW,
    parameter int DEPTH       = PipeStageDepth,
    parameter int STALL_CNT_W = $bits(stall_cnt_t)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         flush,
    input  logic                         up_valid,
    output logic                         up_ready,
    input  logic [PAYLOAD_W-1:0]         up_data,
    output logic                         dn_valid,
    input  logic                         dn_ready,
    output logic [PAYLOAD_W-1:0]         dn_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [STALL_CNT_W-1:0]       stall_cycles
);

    localparam int PtrW = ptr_w(DEPTH);
    localparam int OccW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [OccW-1:0] FullOcc = OccW'(DEPTH);

    logic [PtrW-1:0] rd_ptr, wr_ptr;
    logic [OccW-1:0] occ;
    logic            push, pop;

    assign up_ready  = (occ != FullOcc);
    assign dn_valid  = (occ != '0);
    assign occupancy = occ;

    assign push = up_valid & up_ready & ~flush;
    assign pop  = dn_valid & dn_ready & ~flush;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cycles <= '0;
        end else if (dn_valid && !dn_ready && !flush && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Head is read straight out of storage; storage is never written at rd_ptr
    // while occupied, so dn_data stays put until a pop.
    pipe_stage_mem #(
        .DEPTH     (DEPTH),
        .PAYLOAD_W (PAYLOAD_W),
        .AW        (PtrW)
    ) u_mem (
        .clk   (clk),
        .nrst  (nrst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (up_data),
        .raddr (rd_ptr),
        .rdata (dn_data)
    );

    a_up_hold: assert property (@(posedge clk) disable iff (!nrst)
        (up_valid && !up_ready && !flush) |=> (up_valid && $stable(up_data)));

    a_dn_hold: assert property (@(posedge clk) disable iff (!nrst)
        (dn_valid && !dn_ready && !flush) |=> (dn_valid && $stable(dn_data)));

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage: default config table, DEPTH=3 stream
// against a queue, and 4-bit stall counter saturation plus async reset.
module tb_pipe_elastic_stage;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // Instance A: defaults (96-bit payload, DEPTH=2, 16-bit counter)
    logic        fl_a, uv_a, ur_a, dv_a, dr_a;
    logic [95:0] ud_a, dd_a;
    logic [1:0]  occ_a;
    logic [15:0] st_a;

    // Instance B: DEPTH=3, 8-bit payload
    logic        fl_b, uv_b, ur_b, dv_b, dr_b;
    logic [7:0]  ud_b, dd_b;
    logic [1:0]  occ_b;
    logic [15:0] st_b;

    // Instance C: DEPTH=2, 4-bit stall counter
    logic        fl_c, uv_c, ur_c, dv_c, dr_c;
    logic [7:0]  ud_c, dd_c;
    logic [1:0]  occ_c;
    logic [3:0]  st_c;

    pipe_elastic_stage dut_a (
        .clk(clk), .nrst(nrst), .flush(fl_a), .up_valid(uv_a), .up_ready(ur_a),
        .up_data(ud_a), .dn_valid(dv_a), .dn_ready(dr_a), .dn_data(dd_a),
        .occupancy(occ_a), .stall_cycles(st_a));

    pipe_elastic_stage #(.PAYLOAD_W(8), .DEPTH(3), .STALL_CNT_W(16)) dut_b (
        .clk(clk), .nrst(nrst), .flush(fl_b), .up_valid(uv_b), .up_ready(ur_b),
        .up_data(ud_b), .dn_valid(dv_b), .dn_ready(dr_b), .dn_data(dd_b),
        .occupancy(occ_b), .stall_cycles(st_b));

    pipe_elastic_stage #(.PAYLOAD_W(8), .DEPTH(2), .STALL_CNT_W(4)) dut_c (
        .clk(clk), .nrst(nrst), .flush(fl_c), .up_valid(uv_c), .up_ready(ur_c),
        .up_data(ud_c), .dn_valid(dv_c), .dn_ready(dr_c), .dn_data(dd_c),
        .occupancy(occ_c), .stall_cycles(st_c));

    typedef struct {
        logic        fl, uv, dr;
        logic [95:0] d;
        logic        e_ur, e_dv, chk_d;
        logic [95:0] e_d;
        logic [1:0]  e_occ;
        logic [15:0] e_st;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic fl, uv, input logic [95:0] d, input logic dr,
                                input logic e_ur, e_dv, chk_d, input logic [95:0] e_d,
                                input logic [1:0] e_occ, input logic [15:0] e_st);
        vec_t v;
        v.fl = fl; v.uv = uv; v.d = d; v.dr = dr;
        v.e_ur = e_ur; v.e_dv = e_dv; v.chk_d = chk_d; v.e_d = e_d;
        v.e_occ = e_occ; v.e_st = e_st;
        return v;
    endfunction

    logic [7:0] sb[$];
    int sent, got;

    initial begin
        nrst = 1'b0;
        {fl_a, uv_a, dr_a, ud_a} = '0;
        {fl_b, uv_b, dr_b, ud_b} = '0;
        {fl_c, uv_c, dr_c, ud_c} = '0;

        // Stream 1..8 at full rate, then empty
        vq.push_back(mk(0, 1, 96'h1, 1, 1, 0, 1, 96'h0, 0, 0));
        for (int k = 1; k < 8; k++)
            vq.push_back(mk(0, 1, 96'(k + 1), 1, 1, 1, 1, 96'(k), 1, 0));
        vq.push_back(mk(0, 0, 96'h0, 1, 1, 1, 1, 96'h8, 1, 0));
        vq.push_back(mk(0, 0, 96'h0, 0, 1, 0, 0, 96'h0, 0, 0));
        // Fill with A,B under back-pressure; stall counts while held
        vq.push_back(mk(0, 1, 96'hA, 0, 1, 0, 0, 96'h0, 0, 0));
        vq.push_back(mk(0, 1, 96'hB, 0, 1, 1, 1, 96'hA, 1, 0));
        vq.push_back(mk(0, 0, 96'h0, 0, 0, 1, 1, 96'hA, 2, 1));
        vq.push_back(mk(0, 0, 96'h0, 0, 0, 1, 1, 96'hA, 2, 2));
        // Full + pop: C refused this cycle, accepted next
        vq.push_back(mk(0, 1, 96'hC, 1, 0, 1, 1, 96'hA, 2, 3));
        vq.push_back(mk(0, 1, 96'hC, 1, 1, 1, 1, 96'hB, 1, 3));
        vq.push_back(mk(0, 0, 96'h0, 1, 1, 1, 1, 96'hC, 1, 3));
        vq.push_back(mk(0, 0, 96'h0, 0, 1, 0, 0, 96'h0, 0, 3));
        // Fill to 2 then flush with D offered; storage keeps 0x12 at slot 0
        vq.push_back(mk(0, 1, 96'h11, 0, 1, 0, 0, 96'h0, 0, 3));
        vq.push_back(mk(0, 1, 96'h12, 0, 1, 1, 1, 96'h11, 1, 3));
        vq.push_back(mk(1, 1, 96'hD, 0, 0, 1, 1, 96'h11, 2, 4));
        vq.push_back(mk(0, 0, 96'h0, 1, 1, 0, 1, 96'h12, 0, 4));
        // Flush while empty, then flush ignoring a same-cycle push and pop
        vq.push_back(mk(1, 0, 96'h0, 0, 1, 0, 1, 96'h12, 0, 4));
        vq.push_back(mk(0, 1, 96'h21, 0, 1, 0, 1, 96'h12, 0, 4));
        vq.push_back(mk(1, 1, 96'h22, 1, 1, 1, 1, 96'h21, 1, 4));
        vq.push_back(mk(0, 0, 96'h0, 0, 1, 0, 1, 96'h21, 0, 4));

        tick();
        tick();
        #1;
        chk("rst ur", 128'(ur_a), 128'(1));
        chk("rst dv", 128'(dv_a), 128'(0));
        chk("rst occ", 128'(occ_a), 128'(0));
        chk("rst st", 128'(st_a), 128'(0));
        chk("rst data", 128'(dd_a), 128'(0));
        tick();
        nrst = 1'b1;

        foreach (vq[i]) begin
            fl_a = vq[i].fl; uv_a = vq[i].uv; ud_a = vq[i].d; dr_a = vq[i].dr;
            #1;
            chk($sformatf("v%0d up_ready", i), 128'(ur_a), 128'(vq[i].e_ur));
            chk($sformatf("v%0d dn_valid", i), 128'(dv_a), 128'(vq[i].e_dv));
            chk($sformatf("v%0d occupancy", i), 128'(occ_a), 128'(vq[i].e_occ));
            chk($sformatf("v%0d stall", i), 128'(st_a), 128'(vq[i].e_st));
            if (vq[i].chk_d) chk($sformatf("v%0d dn_data", i), 128'(dd_a), 128'(vq[i].e_d));
            tick();
        end
        {fl_a, uv_a, dr_a, ud_a} = '0;

        // DEPTH=3: ten entries against random back-pressure, queue scoreboard
        sent = 0;
        got  = 0;
        for (int c = 0; c < 400 && got < 10; c++) begin
            uv_b = (sent < 10);
            ud_b = 8'(sent + 1);
            dr_b = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("d3 c%0d occupancy", c), 128'(occ_b), 128'(sb.size()));
            if (dv_b && dr_b) begin
                if (sb.size() == 0) begin
                    chk($sformatf("d3 c%0d spurious pop", c), 128'(dd_b), 128'hFFFF_FFFF);
                end else begin
                    chk($sformatf("d3 c%0d dn_data", c), 128'(dd_b), 128'(sb[0]));
                    void'(sb.pop_front());
                end
                got++;
            end
            if (uv_b && ur_b) begin
                sb.push_back(ud_b);
                sent++;
            end
            tick();
        end
        chk("d3 delivered", 128'(got), 128'(10));
        uv_b = 1'b0;
        dr_b = 1'b1;
        tick();
        #1;
        chk("d3 drained", 128'(dv_b), 128'(0));

        // 4-bit counter saturates at 15 and holds
        uv_c = 1'b1; ud_c = 8'h5A; dr_c = 1'b0;
        tick();
        uv_c = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14) begin
                #1;
                chk("sat n14", 128'(st_c), 128'(14));
            end
        end
        #1;
        chk("sat n20", 128'(st_c), 128'(15));
        chk("sat dv", 128'(dv_c), 128'(1));
        chk("sat data", 128'(dd_c), 128'h5A);

        // Reset mid-cycle, well away from a clock edge
        #1;
        nrst = 1'b0;
        #1;
        chk("async rst dv", 128'(dv_c), 128'(0));
        chk("async rst ur", 128'(ur_c), 128'(1));
        chk("async rst occ", 128'(occ_c), 128'(0));
        chk("async rst st", 128'(st_c), 128'(0));
        chk("async rst data", 128'(dd_c), 128'(0));
        tick();
        nrst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
